// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, per-bit debounce, press / long-press strobes
// and optional auto-repeat press strobes for the watch mode and setting logic.
module button_conditioner #(
   parameter int              NBTN        = 5,
   parameter int              DB_CYCLES   = 500000,
   parameter int              HOLD_CYCLES = 50000000,
   parameter int              RPT_CYCLES  = 10000000,
   parameter logic [NBTN-1:0] RPT_MASK    = NBTN'(5'b00100),
   parameter int              CNT_W       = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NBTN-1:0]   btn_raw,
   output logic [NBTN-1:0]   btn_level,
   output logic [NBTN-1:0]   btn_press,
   output logic [NBTN-1:0]   btn_long,
   output logic [2*NBTN-1:0] dbg_state
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_LONG   = 2'd2;
   localparam logic [1:0] ST_REPEAT = 2'd3;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);

   logic [NBTN-1:0]  s1;
   logic [NBTN-1:0]  s2;
   logic [NBTN-1:0]  accept;
   logic [CNT_W-1:0] db_cnt   [NBTN];
   logic [CNT_W-1:0] hold_cnt [NBTN];
   logic [CNT_W-1:0] rpt_cnt  [NBTN];
   logic [1:0]       state    [NBTN];

   // accept marks the edge on which the debounced level takes the synced value
   always_comb begin
      accept    = '0;
      dbg_state = '0;
      for (int i = 0; i < NBTN; i++) begin
         accept[i]           = (s2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
         dbg_state[2*i +: 2] = state[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1        <= '0;
         s2        <= '0;
         btn_level <= '0;
         btn_press <= '0;
         btn_long  <= '0;
         for (int i = 0; i < NBTN; i++) begin
            db_cnt[i]   <= '0;
            hold_cnt[i] <= '0;
            rpt_cnt[i]  <= '0;
            state[i]    <= ST_IDLE;
         end
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         for (int i = 0; i < NBTN; i++) begin
            btn_press[i] <= 1'b0;
            btn_long[i]  <= 1'b0;

            if (s2[i] == btn_level[i]) begin
               db_cnt[i] <= '0;
            end else if (accept[i]) begin
               db_cnt[i]    <= '0;
               btn_level[i] <= s2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end

            // level edges override the per-state timers
            if (accept[i] && s2[i]) begin
               state[i]     <= ST_HELD;
               hold_cnt[i]  <= '0;
               rpt_cnt[i]   <= '0;
               btn_press[i] <= 1'b1;
            end else if (accept[i]) begin
               state[i]    <= ST_IDLE;
               hold_cnt[i] <= '0;
               rpt_cnt[i]  <= '0;
            end else begin
               case (state[i])
                  ST_HELD: begin
                     if (hold_cnt[i] == HOLD_LAST) begin
                        state[i]    <= RPT_MASK[i] ? ST_REPEAT : ST_LONG;
                        btn_long[i] <= 1'b1;
                        rpt_cnt[i]  <= '0;
                     end else begin
                        hold_cnt[i] <= hold_cnt[i] + 1'b1;
                     end
                  end
                  ST_REPEAT: begin
                     if (rpt_cnt[i] == RPT_LAST) begin
                        rpt_cnt[i]   <= '0;
                        btn_press[i] <= 1'b1;
                     end else begin
                        rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat periods;
// each expected value below is derived by hand from the button timing rules.
module tb_button_conditioner;

   localparam int NBTN = 5;

   logic            clk;
   logic            reset;
   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] btn_level;
   logic [NBTN-1:0] btn_press;
   logic [NBTN-1:0] btn_long;
   logic [2*NBTN-1:0] dbg_state;

   int passed;
   int total;

   button_conditioner #(
      .NBTN       (NBTN),
      .DB_CYCLES  (4),
      .HOLD_CYCLES(20),
      .RPT_CYCLES (5),
      .RPT_MASK   (5'b00100),
      .CNT_W      (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_long (btn_long),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one edge, then settle so outputs are sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      logic [6:0] pat;
      passed  = 0;
      total   = 0;
      btn_raw = '0;
      reset   = 1'b1;
      repeat (3) tick();
      chk("rst_level", btn_level, 5'b0);
      chk("rst_press", btn_press, 5'b0);
      chk("rst_long",  btn_long,  5'b0);
      reset = 1'b0;
      repeat (2) tick();

      // 1: bit 0 held 41 clks, long press without repeat
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("t1_level_pre", btn_level[0], 1'b0);
      end
      tick();
      chk("t1_level", btn_level, 5'b00001);
      chk("t1_press", btn_press, 5'b00001);
      chk("t1_long0", btn_long,  5'b0);
      for (int k = 1; k <= 35; k++) begin
         tick();
         chk("t1_press_hold", btn_press[0], 1'b0);
         chk("t1_long_hold",  btn_long[0],  (k == 20) ? 1'b1 : 1'b0);
      end
      btn_raw[0] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("t1_rel_level", btn_level[0], (k < 6) ? 1'b1 : 1'b0);
         chk("t1_rel_press", btn_press, 5'b0);
         chk("t1_rel_long",  btn_long,  5'b0);
      end
      repeat (3) tick();

      // 2: glitchy bit 1 never reaches the debounce threshold
      pat = 7'b1110111;
      for (int k = 0; k < 17; k++) begin
         btn_raw[1] = (k < 7) ? pat[k] : 1'b0;
         tick();
         chk("t2_level", btn_level[1], 1'b0);
         chk("t2_press", btn_press[1], 1'b0);
      end

      // 3: bit 2 long press with auto-repeat, released 49 clks after raw rise
      btn_raw[2] = 1'b1;
      repeat (5) tick();
      chk("t3_level_pre", btn_level[2], 1'b0);
      tick();
      chk("t3_press", btn_press, 5'b00100);
      for (int k = 1; k <= 56; k++) begin
         if (k == 44) btn_raw[2] = 1'b0;
         tick();
         chk("t3_rpt_press", btn_press[2],
             (k >= 25 && k <= 45 && (k % 5) == 0) ? 1'b1 : 1'b0);
         chk("t3_long",  btn_long[2],  (k == 20) ? 1'b1 : 1'b0);
         chk("t3_level", btn_level[2], (k < 49) ? 1'b1 : 1'b0);
      end

      // 4: bits 0 and 3 together
      btn_raw = 5'b01001;
      repeat (5) tick();
      chk("t4_press_pre", btn_press, 5'b0);
      tick();
      chk("t4_press", btn_press, 5'b01001);
      chk("t4_level", btn_level, 5'b01001);
      tick();
      chk("t4_press_off", btn_press, 5'b0);
      btn_raw = 5'b0;
      repeat (8) tick();
      chk("t4_rel_level", btn_level, 5'b0);

      // 5: reset while bit 2 is auto-repeating and still held
      btn_raw[2] = 1'b1;
      repeat (6) tick();
      chk("t5_press", btn_press, 5'b00100);
      repeat (25) tick();
      chk("t5_rpt", btn_press, 5'b00100);
      repeat (2) tick();
      chk("t5_state", dbg_state[5:4], 2'd3);
      reset = 1'b1;
      tick();
      chk("t5_rst_level", btn_level, 5'b0);
      chk("t5_rst_press", btn_press, 5'b0);
      chk("t5_rst_long",  btn_long,  5'b0);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("t5_redb_press", btn_press[2], 1'b0);
      end
      tick();
      chk("t5_fresh_press", btn_press, 5'b00100);
      chk("t5_fresh_level", btn_level, 5'b00100);
      btn_raw[2] = 1'b0;
      repeat (8) tick();
      chk("t5_rel_level", btn_level, 5'b0);

      // 6: bit 4 released at hold count 10, then a full hold
      btn_raw[4] = 1'b1;
      repeat (6) tick();
      chk("t6_press", btn_press, 5'b10000);
      repeat (4) tick();
      btn_raw[4] = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         chk("t6_no_long", btn_long[4], 1'b0);
         chk("t6_rel_level", btn_level[4], (k < 6) ? 1'b1 : 1'b0);
      end
      btn_raw[4] = 1'b1;
      repeat (6) tick();
      chk("t6_repress", btn_press, 5'b10000);
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk("t6_long_pre", btn_long[4], 1'b0);
      end
      tick();
      chk("t6_long", btn_long, 5'b10000);
      chk("t6_long_nopress", btn_press, 5'b0);
      btn_raw[4] = 1'b0;
      repeat (8) tick();
      chk("t6_end_level", btn_level, 5'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
